// File: rtl/ysyx_25020037_axi_pkg.sv
// Shared encodings for the AXI4 read-channel responder: FSM states, burst types, response codes.
package ysyx_25020037_axi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      SEND = 2'b10
   } state_t;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Only FIXED and INCR with beats no wider than the 32-bit data bus are served.
   function automatic logic beat_supported(input logic [2:0] size, input logic [1:0] burst);
      return (size <= 3'd2) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
   endfunction

endpackage

// File: rtl/ysyx_25020037_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), loaded with seed on reset and stepped every cycle.
module ysyx_25020037_lfsr8 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seed,
   output logic [7:0] out
);

   logic [7:0] r_lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= seed;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign out = r_lfsr;

endmodule

// File: rtl/ysyx_25020037_axi_rd_slave.sv
// AXI4 read responder (AR + R) over an internal word memory with a synchronous preload port.
// Define YSYX_25020037_AXI_RAND_DELAY_EN to add LFSR-driven idle cycles before and between beats.
module ysyx_25020037_axi_rd_slave
   import ysyx_25020037_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'hA0000000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [3:0]  rid,
   input  logic        pl_we,
   input  logic [31:0] pl_addr,
   input  logic [31:0] pl_wdata
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = DEPTH_WORDS * 4;

   if (LATENCY > 15) begin : g_bad_latency
      $error("LATENCY must be within 0..15");
   end
   if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two");
   end
   if (LFSR_SEED == 8'h00) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end

   logic [31:0] r_mem [DEPTH_WORDS];

   state_t      r_state;
   logic        r_arready;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;
   logic        r_rlast;
   logic [3:0]  r_rid;
   logic [31:0] r_addr;
   logic [3:0]  r_id;
   logic [7:0]  r_len;
   logic [2:0]  r_size;
   logic [1:0]  r_burst;
   logic [7:0]  r_beat;
   logic [4:0]  r_dly;

   logic [4:0]  w_rand;
   logic [4:0]  w_first_dly;
   logic [31:0] w_pl_off;
   logic        w_pl_hit;
   logic [31:0] w_next_addr;
   logic [31:0] w_ld_addr;
   logic [31:0] w_ld_off;
   logic [2:0]  w_ld_size;
   logic [1:0]  w_ld_burst;
   logic [7:0]  w_ld_beat;
   logic [7:0]  w_ld_len;
   logic [3:0]  w_ld_id;
   logic        w_ld_last;
   logic [31:0] w_ld_data;
   logic [1:0]  w_ld_resp;
   logic        w_load;

`ifdef YSYX_25020037_AXI_RAND_DELAY_EN
   logic [7:0] w_lfsr;

   ysyx_25020037_lfsr8 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .out  (w_lfsr)
   );

   assign w_rand = {3'b000, w_lfsr[1:0]};
`else
   assign w_rand = '0;
`endif

   assign w_first_dly = 5'(LATENCY) + w_rand;

   assign w_pl_off = pl_addr - BASE_ADDR;
   assign w_pl_hit = (w_pl_off < SPAN);

   always_ff @(posedge clk) begin
      if (pl_we && w_pl_hit) begin
         r_mem[w_pl_off[AW+1:2]] <= pl_wdata;
      end
   end

   assign w_next_addr = (r_burst == BURST_FIXED) ? r_addr : r_addr + (32'd1 << r_size);

   // The beat about to be loaded comes from the AR bus in IDLE, from the advanced
   // address on a back-to-back handshake in SEND, and from the stored state in WAIT.
   always_comb begin
      w_ld_addr  = r_addr;
      w_ld_size  = r_size;
      w_ld_burst = r_burst;
      w_ld_beat  = r_beat;
      w_ld_len   = r_len;
      w_ld_id    = r_id;
      case (r_state)
         IDLE: begin
            w_ld_addr  = araddr;
            w_ld_size  = arsize;
            w_ld_burst = arburst;
            w_ld_beat  = '0;
            w_ld_len   = arlen;
            w_ld_id    = arid;
         end
         SEND: begin
            w_ld_addr = w_next_addr;
            w_ld_beat = r_beat + 8'd1;
         end
         default: ;
      endcase
   end

   assign w_ld_off  = w_ld_addr - BASE_ADDR;
   assign w_ld_last = (w_ld_beat == w_ld_len);

   always_comb begin
      w_ld_data = '0;
      w_ld_resp = RESP_OKAY;
      if (!beat_supported(w_ld_size, w_ld_burst)) begin
         w_ld_resp = RESP_SLVERR;
      end else if (w_ld_off >= SPAN) begin
         w_ld_resp = RESP_DECERR;
      end else begin
         w_ld_data = r_mem[w_ld_off[AW+1:2]];
      end
   end

   always_comb begin
      w_load = 1'b0;
      case (r_state)
         IDLE:    w_load = arvalid && (w_first_dly == 5'd0);
         WAIT:    w_load = (r_dly == 5'd0);
         SEND:    w_load = rready && !r_rlast && (w_rand == 5'd0);
         default: w_load = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_addr    <= '0;
         r_id      <= '0;
         r_len     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_beat    <= '0;
         r_dly     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (arvalid) begin
                  r_addr    <= araddr;
                  r_id      <= arid;
                  r_len     <= arlen;
                  r_size    <= arsize;
                  r_burst   <= arburst;
                  r_beat    <= '0;
                  r_arready <= 1'b0;
                  if (w_first_dly == 5'd0) begin
                     r_state <= SEND;
                  end else begin
                     r_dly   <= w_first_dly - 5'd1;
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (r_dly == 5'd0) begin
                  r_state <= SEND;
               end else begin
                  r_dly <= r_dly - 5'd1;
               end
            end
            SEND: begin
               if (rready) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_state   <= IDLE;
                  end else begin
                     r_addr <= w_next_addr;
                     r_beat <= r_beat + 8'd1;
                     if (w_rand != 5'd0) begin
                        r_rvalid <= 1'b0;
                        r_dly    <= w_rand - 5'd1;
                        r_state  <= WAIT;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_load) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ld_data;
            r_rresp  <= w_ld_resp;
            r_rlast  <= w_ld_last;
            r_rid    <= w_ld_id;
         end
      end
   end

   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;
   assign rlast   = r_rlast;
   assign rid     = r_rid;

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_slave.sv
// Directed bench for ysyx_25020037_axi_rd_slave: vector table of reads plus stall, collision and reset sequences.
module tb_ysyx_25020037_axi_rd_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   logic        pl_we;
   logic [31:0] pl_addr;
   logic [31:0] pl_wdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [31:0] d [4];
      logic [1:0]  r [4];
   } vec_t;

   vec_t vecs [10];

   ysyx_25020037_axi_rd_slave dut (
      .clk      (clk),
      .rst      (rst),
      .arvalid  (arvalid),
      .arready  (arready),
      .araddr   (araddr),
      .arid     (arid),
      .arlen    (arlen),
      .arsize   (arsize),
      .arburst  (arburst),
      .rvalid   (rvalid),
      .rready   (rready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rlast    (rlast),
      .rid      (rid),
      .pl_we    (pl_we),
      .pl_addr  (pl_addr),
      .pl_wdata (pl_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                          input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] r3);
      vecs[i].addr  = a;
      vecs[i].id    = id;
      vecs[i].len   = len;
      vecs[i].size  = sz;
      vecs[i].burst = bu;
      vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2; vecs[i].d[3] = d3;
      vecs[i].r[0] = r0; vecs[i].r[1] = r1; vecs[i].r[2] = r2; vecs[i].r[3] = r3;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_we    = 1'b1;
      pl_addr  = a;
      pl_wdata = d;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
      @(negedge clk);
      araddr  = a;
      arid    = id;
      arlen   = len;
      arsize  = sz;
      arburst = bu;
      arvalid = 1'b1;
      chk("arready_idle", 32'(arready), 32'd1);
      @(posedge clk);
      #1;
      arvalid = 1'b0;
   endtask

   // Counts falling edges after the handshake edge until rvalid is seen (bounded).
   task automatic wait_beat(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (rvalid !== 1'b1 && lat < 40);
   endtask

   task automatic check_beat(input string tag, input int lat, input int exp_lat, input logic [31:0] d,
                             input logic [1:0] r, input logic last, input logic [3:0] id);
      chk({tag, "_lat"},   32'(lat),   32'(exp_lat));
      chk({tag, "_rdata"}, rdata,      d);
      chk({tag, "_rresp"}, 32'(rresp), 32'(r));
      chk({tag, "_rlast"}, 32'(rlast), 32'(last));
      chk({tag, "_rid"},   32'(rid),   32'(id));
   endtask

   task automatic check_idle_after(input string tag);
      @(negedge clk);
      chk({tag, "_rvalid_drop"}, 32'(rvalid),  32'd0);
      chk({tag, "_arready_up"},  32'(arready), 32'd1);
   endtask

   task automatic do_vec(input int i);
      vec_t v;
      int   lat;
      v = vecs[i];
      send_ar(v.addr, v.id, v.len, v.size, v.burst);
      for (int b = 0; b <= int'(v.len); b++) begin
         wait_beat(lat);
         check_beat($sformatf("v%0d_b%0d", i, b), lat, (b == 0) ? 3 : 1, v.d[b], v.r[b],
                    (b == int'(v.len)), v.id);
      end
      check_idle_after($sformatf("v%0d", i));
   endtask

   task automatic read_single(input string tag, input logic [31:0] a, input logic [3:0] id, input logic [31:0] d);
      int lat;
      send_ar(a, id, 8'd0, 3'd2, 2'b01);
      wait_beat(lat);
      check_beat(tag, lat, 3, d, 2'b00, 1'b1, id);
      check_idle_after(tag);
   endtask

   initial begin
      int lat;
      rst = 1'b1; arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
      rready = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_wdata = '0;

      repeat (2) @(negedge clk);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      chk("rst_rresp",   32'(rresp),   32'd0);
      chk("rst_rlast",   32'(rlast),   32'd0);
      chk("rst_rid",     32'(rid),     32'd0);
      rst = 1'b0;

      for (int w = 0; w < 8; w++) begin
         preload(32'hA000_0000 + 32'(w * 4), 32'h1111_0000 | 32'(w));
      end
      preload(32'hA000_0010, 32'hDEAD_BEEF);
      preload(32'hA000_0FFC, 32'hCAFE_F00D);
      // Just past the end: must be dropped, not aliased onto word 0.
      preload(32'hA000_1000, 32'hFFFF_FFFF);
      @(negedge clk);
      pl_we = 1'b0;

      set_vec(0, 32'hA000_0010, 4'h3, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 0, 0, 0);
      set_vec(1, 32'hA000_0000, 4'h5, 8'd3, 3'd2, 2'b01, 32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003,
              2'b00, 2'b00, 2'b00, 2'b00);
      set_vec(2, 32'hA000_0008, 4'h1, 8'd2, 3'd2, 2'b00, 32'h1111_0002, 32'h1111_0002, 32'h1111_0002, 0,
              2'b00, 2'b00, 2'b00, 0);
      set_vec(3, 32'h8000_0000, 4'h2, 8'd0, 3'd2, 2'b01, 0, 0, 0, 0, 2'b11, 0, 0, 0);
      set_vec(4, 32'hA000_0FFC, 4'h7, 8'd1, 3'd2, 2'b01, 32'hCAFE_F00D, 0, 0, 0, 2'b00, 2'b11, 0, 0);
      set_vec(5, 32'hA000_0000, 4'h9, 8'd1, 3'd2, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0);
      set_vec(6, 32'hA000_0000, 4'hA, 8'd1, 3'd3, 2'b01, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0);
      set_vec(7, 32'hA000_0004, 4'hB, 8'd1, 3'd0, 2'b01, 32'h1111_0001, 32'h1111_0001, 0, 0, 2'b00, 2'b00, 0, 0);
      set_vec(8, 32'hA000_001C, 4'hC, 8'd0, 3'd2, 2'b11, 0, 0, 0, 0, 2'b10, 0, 0, 0);
      set_vec(9, 32'hA000_001C, 4'hF, 8'd0, 3'd2, 2'b01, 32'h1111_0007, 0, 0, 0, 2'b00, 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         do_vec(i);
      end

      // INCR burst of 4 with rready low for two cycles while beat 2 is presented.
      send_ar(32'hA000_0000, 4'h6, 8'd3, 3'd2, 2'b01);
      wait_beat(lat);
      check_beat("stall_b0", lat, 3, 32'h1111_0000, 2'b00, 1'b0, 4'h6);
      wait_beat(lat);
      check_beat("stall_b1", lat, 1, 32'h1111_0001, 2'b00, 1'b0, 4'h6);
      rready = 1'b0;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         chk($sformatf("stall_hold%0d_rvalid", s), 32'(rvalid), 32'd1);
         chk($sformatf("stall_hold%0d_rdata", s),  rdata,       32'h1111_0001);
         chk($sformatf("stall_hold%0d_rlast", s),  32'(rlast),  32'd0);
         chk($sformatf("stall_hold%0d_rid", s),    32'(rid),    32'd6);
      end
      rready = 1'b1;
      wait_beat(lat);
      check_beat("stall_b2", lat, 1, 32'h1111_0002, 2'b00, 1'b0, 4'h6);
      wait_beat(lat);
      check_beat("stall_b3", lat, 1, 32'h1111_0003, 2'b00, 1'b1, 4'h6);
      check_idle_after("stall");

      // Preload of the same word in the beat-loading cycle: reader sees the old value.
      send_ar(32'hA000_0014, 4'h4, 8'd0, 3'd2, 2'b01);
      @(negedge clk);
      @(negedge clk);
      pl_we    = 1'b1;
      pl_addr  = 32'hA000_0014;
      pl_wdata = 32'h55AA_55AA;
      @(negedge clk);
      pl_we = 1'b0;
      chk("coll_rvalid", 32'(rvalid), 32'd1);
      chk("coll_rdata",  rdata,       32'h1111_0005);
      check_idle_after("coll");
      read_single("coll_after", 32'hA000_0014, 4'h4, 32'h55AA_55AA);

      // Reset while beat 2 of an 8-beat burst is presented.
      send_ar(32'hA000_0000, 4'hD, 8'd7, 3'd2, 2'b01);
      wait_beat(lat);
      check_beat("rstb_b0", lat, 3, 32'h1111_0000, 2'b00, 1'b0, 4'hD);
      wait_beat(lat);
      check_beat("rstb_b1", lat, 1, 32'h1111_0001, 2'b00, 1'b0, 4'hD);
      rst = 1'b1;
      #1;
      chk("rstb_rvalid_async",  32'(rvalid),  32'd0);
      chk("rstb_arready_async", 32'(arready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstb_rlast", 32'(rlast), 32'd0);
      chk("rstb_rid",   32'(rid),   32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("rstb_quiet_rvalid", 32'(rvalid),  32'd0);
         chk("rstb_arready",      32'(arready), 32'd1);
      end
      read_single("rstb_after", 32'hA000_0010, 4'h8, 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_25020037_axi_rd_slave.md
Name: ysyx_25020037_axi_rd_slave

Overview:
AXI4 read-channel responder (AR + R only) backed by an internal word-addressed memory. It serves the IFU/LSU read initiators in simulation and SoC-less builds, returns single and burst beats, and reports access errors through rresp. A simple synchronous preload port fills the memory before and during the test.

Parameters:
BASE_ADDR, 32'hA0000000, byte address mapped to word 0.
DEPTH_WORDS, 1024, number of 32-bit words; power of two.
LATENCY, 2, idle cycles between the AR handshake and the first rvalid; range 0..15.
LFSR_SEED, 8'hA5, nonzero seed for the optional delay LFSR.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
araddr  in  32  byte address of the first beat.
arid  in  4  transaction ID.
arlen  in  8  number of beats minus 1.
arsize  in  3  log2 of bytes per beat.
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
rdata  out  32  read data.
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
rlast  out  1  final beat of the burst.
rid  out  4  echoes the captured arid.
pl_we  in  1  preload write enable.
pl_addr  in  32  preload byte address (word-aligned).
pl_wdata  in  32  preload data.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset: state IDLE, arready=1, rvalid=0, rdata=0, rresp=00, rlast=0, rid=0, all counters 0. Memory contents are not reset.
- States:
  - IDLE: arready=1. On arvalid&arready, capture araddr, arid, arlen, arsize, arburst; clear beat_cnt; load dly_cnt=LATENCY; go to WAIT.
  - WAIT: arready=0. Decrement dly_cnt each cycle. When dly_cnt==0, load the beat registers, set rvalid=1, go to SEND. With LATENCY=0, a handshake in cycle T gives rvalid in cycle T+1; in general rvalid rises at T+1+LATENCY.
  - SEND: rvalid, rdata, rresp, rlast and rid hold stable while rready=0.
    - On rvalid&rready with rlast=0: advance the address and beat_cnt. The next beat is valid in the following cycle, so bursts are back-to-back.
    - On rvalid&rready with rlast=1: clear rvalid and rlast, go to IDLE. arready rises in the following cycle.
- Address advance: INCR adds (1<<arsize) with 32-bit wrap-around. FIXED keeps the address constant.
- rlast is 1 exactly when beat_cnt==arlen. arlen=0 gives a single beat; arlen=255 gives 256 beats (beat_cnt is 8 bits).
- Response per beat:
  - arsize>2 or arburst=WRAP or arburst=11: SLVERR on every beat, rdata=0.
  - Beat address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4): DECERR, rdata=0. This is evaluated per beat, so a burst that runs off the end switches to DECERR mid-burst.
  - Otherwise: OKAY, rdata = mem[(addr-BASE_ADDR)>>2]. The full aligned word is returned and the master selects byte lanes for narrow sizes.
- Preload port: a write at pl_we with an in-range address takes effect at the clock edge. Out-of-range preload writes are ignored.
- Preload/read collision: rdata is registered when a beat is loaded. A preload of the same word in the loading cycle returns the old value to the reader.
- Reset mid-burst: the block returns to IDLE immediately, rvalid drops asynchronously, and the remaining beats are discarded.

Optional Feature:
YSYX_25020037_AXI_RAND_DELAY_EN
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seeded with LFSR_SEED, stepped every cycle) adds lfsr[1:0] extra idle cycles before the first beat and between consecutive beats. Between beats, rvalid is 0 for the extra cycles. Handshake rules are unchanged.
- Undefined: timing is exactly as described in Behaviour, and no LFSR is instantiated.

Decomposition:
- Package ysyx_25020037_axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR/DECERR, and the state encodings IDLE=2'b00, WAIT=2'b01, SEND=2'b10.
- Sub-module ysyx_25020037_lfsr8 (clk, rst, seed, out[7:0]), instantiated only under the macro.

Test Plan:
- Single read: preload 0xA0000010 with 0xDEADBEEF; issue AR with arlen=0, arsize=2, INCR → the handshake is in cycle T; rvalid, rlast=1, rresp=00, rdata=0xDEADBEEF, rid=arid arrive in cycle T+3.
- INCR burst of 4 from 0xA0000000 with rready low for 2 cycles on beat 2 → the bench sees words 0..3 in order; beat 2 is held stable during the stall; rlast only on beat 4.
- FIXED burst, arlen=2, at 0xA0000008 → three beats, each equal to mem[2].
- Out-of-range and run-off:
  - araddr=0x80000000 → DECERR with rdata=0.
  - INCR arlen=1 at BASE+DEPTH_WORDS*4-4 → OKAY, then DECERR.
- arburst=WRAP, or arsize=3 with arlen=1 → two beats, both SLVERR.
- Reset asserted during beat 2 of an 8-beat burst → rvalid=0 immediately; arready=1 after reset; a new single read completes correctly.
